// File: rtl/axi_mst_pkg.sv
// Shared types and constants for the AXI4 burst master.
// Contents: FSM state enum, AXI response codes, INCR burst code, response max helper.
// Optional feature macro used by the top: AXI_MST_4K_CHECK_EN.
package axi_mst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // Worst-of-two response; the codes are ordered by severity numerically.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mst_beat_cnt.sv
// Beat counter shared by the write-data and read-data phases.
// Ports:
//   ACLK, ARESETn  clock, asynchronous active-low reset
//   i_clr          clear count to zero (command accepted)
//   i_inc          one beat handshaked
//   i_len          burst length minus one
//   o_last         current beat is the final beat (count == len)
module axi_mst_beat_cnt #(
  parameter int LEN_W = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_last
);

  logic [LEN_W-1:0] r_cnt;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_last = (r_cnt == i_len);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 master: turns each client command into one INCR
// burst, streams write/read beats straight through, and reports a single
// completion per command (worst response plus a protocol-error flag for
// ID mismatch or misplaced RLAST).
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   cmd_*                         command stream (write/read, id, addr, len)
//   wd_*                          write-data stream from the client
//   rd_*                          read-data stream to the client
//   rsp_valid/rsp_resp/rsp_err    one-cycle completion pulse
//   AW*/W*/B*/AR*/R*              AXI4 master channels
// Macro AXI_MST_4K_CHECK_EN: commands whose burst would cross a 4 KB
// boundary are accepted but answered locally with SLVERR + rsp_err.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// AW    | presenting write address
// W     | passing write beats through
// B     | waiting for write response
// AR    | presenting read address
// R     | passing read beats through, accumulating response/errors
module axi_burst_master
  import axi_mst_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                rsp_valid,
  output logic [1:0]          rsp_resp,
  output logic                rsp_err,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [LEN_W-1:0]    AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [LEN_W-1:0]    ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));

  state_t            r_state;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_awvalid;
  logic              r_arvalid;
  logic              r_bready;
  logic              r_rsp_valid;
  logic [1:0]        r_rsp_resp;
  logic              r_rsp_err;
  logic [1:0]        r_acc_resp;
  logic              r_acc_err;

  logic w_cmd_hs;
  logic w_w_hs;
  logic w_r_hs;
  logic w_last;
  logic w_r_beat_err;

  assign w_cmd_hs = (r_state == ST_IDLE) && cmd_valid;
  assign w_w_hs   = (r_state == ST_W) && wd_valid && WREADY;
  assign w_r_hs   = (r_state == ST_R) && RVALID && rd_ready;

  // A beat is bad if its ID is wrong or RLAST disagrees with our own count.
  assign w_r_beat_err = (RID != r_id) || (RLAST != w_last);

`ifdef AXI_MST_4K_CHECK_EN
  logic [31:0] w_burst_end;
  logic        w_cross_4k;
  assign w_burst_end = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(DATA_W / 8);
  assign w_cross_4k  = (w_burst_end > 32'd4096);
`endif

  axi_mst_beat_cnt #(
    .LEN_W (LEN_W)
  ) u_beat_cnt (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_clr   (w_cmd_hs),
    .i_inc   (w_w_hs || w_r_hs),
    .i_len   (r_len),
    .o_last  (w_last)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_awvalid   <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_resp  <= OKAY;
      r_rsp_err   <= 1'b0;
      r_acc_resp  <= OKAY;
      r_acc_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_id       <= cmd_id;
            r_addr     <= cmd_addr;
            r_len      <= cmd_len;
            r_acc_resp <= OKAY;
            r_acc_err  <= 1'b0;
`ifdef AXI_MST_4K_CHECK_EN
            if (w_cross_4k) begin
              // Answered locally; no AXI traffic for this command.
              r_rsp_valid <= 1'b1;
              r_rsp_resp  <= SLVERR;
              r_rsp_err   <= 1'b1;
            end else
`endif
            if (cmd_write) begin
              r_state   <= ST_AW;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= ST_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_AW: begin
          if (AWREADY) begin
            r_awvalid <= 1'b0;
            r_state   <= ST_W;
          end
        end
        ST_W: begin
          if (w_w_hs && w_last) begin
            r_bready <= 1'b1;
            r_state  <= ST_B;
          end
        end
        ST_B: begin
          if (BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_resp  <= BRESP;
            r_rsp_err   <= (BID != r_id);
            r_state     <= ST_IDLE;
          end
        end
        ST_AR: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (w_r_hs) begin
            // Completion is driven by our count, not by RLAST.
            if (w_last) begin
              r_rsp_valid <= 1'b1;
              r_rsp_resp  <= resp_max(r_acc_resp, RRESP);
              r_rsp_err   <= r_acc_err || w_r_beat_err;
              r_state     <= ST_IDLE;
            end else begin
              r_acc_resp <= resp_max(r_acc_resp, RRESP);
              r_acc_err  <= r_acc_err || w_r_beat_err;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);

  assign AWID    = r_id;
  assign AWADDR  = r_addr;
  assign AWLEN   = r_len;
  assign AWSIZE  = AXSIZE;
  assign AWBURST = BURST_INCR;
  assign AWVALID = r_awvalid;

  assign WVALID   = (r_state == ST_W) && wd_valid;
  assign wd_ready = (r_state == ST_W) && WREADY;
  assign WDATA    = wd_data;
  assign WSTRB    = wd_strb;
  assign WLAST    = (r_state == ST_W) && w_last;
  assign BREADY   = r_bready;

  assign ARID    = r_id;
  assign ARADDR  = r_addr;
  assign ARLEN   = r_len;
  assign ARSIZE  = AXSIZE;
  assign ARBURST = BURST_INCR;
  assign ARVALID = r_arvalid;

  assign rd_valid = (r_state == ST_R) && RVALID;
  assign RREADY   = (r_state == ST_R) && rd_ready;
  assign rd_data  = RDATA;
  assign rd_last  = (r_state == ST_R) && w_last;

  assign rsp_valid = r_rsp_valid;
  assign rsp_resp  = r_rsp_resp;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;
  import axi_mst_pkg::*;

`ifdef AXI_MST_4K_CHECK_EN
  localparam bit CHK4K = 1'b1;
`else
  localparam bit CHK4K = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        rsp_valid, rsp_err;
  logic [1:0]  rsp_resp;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_burst_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  logic [31:0] model_mem [1024];
  logic        exp_a_wr[$];
  logic [7:0]  exp_a_id[$];
  logic [31:0] exp_a_addr[$];
  logic [3:0]  exp_a_len[$];
  logic [31:0] exp_w_data[$];
  logic        exp_w_last[$];
  logic [31:0] exp_rd_data[$];
  logic        exp_rd_last[$];
  logic [1:0]  exp_rsp_resp[$];
  logic        exp_rsp_err[$];

  int          rsp_count = 0, rsp_cyc = 0, w_beats = 0, wlast_cnt = 0, rd_beats = 0, rd_last_cnt = 0;
  logic [1:0]  last_resp;
  logic        last_err;
  logic [31:0] rd_hist [16];

  task automatic check_a(input logic wr, input logic [7:0] id, input logic [31:0] ad,
                         input logic [3:0] ln, input logic [2:0] sz, input logic [1:0] bu);
    chk("addr_expected", exp_a_wr.size() > 0, 1);
    if (exp_a_wr.size() > 0) begin
      chk("addr_kind", wr, exp_a_wr.pop_front());
      chk("addr_id", id, exp_a_id.pop_front());
      chk("addr_addr", ad, exp_a_addr.pop_front());
      chk("addr_len", ln, exp_a_len.pop_front());
      chk("addr_size", sz, 3'd2);
      chk("addr_burst", bu, 2'b01);
    end
  endtask

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      exp_a_wr.delete(); exp_a_id.delete(); exp_a_addr.delete(); exp_a_len.delete();
      exp_w_data.delete(); exp_w_last.delete(); exp_rd_data.delete(); exp_rd_last.delete();
      exp_rsp_resp.delete(); exp_rsp_err.delete();
    end else begin
      if (AWVALID && AWREADY) check_a(1'b1, AWID, AWADDR, AWLEN, AWSIZE, AWBURST);
      if (ARVALID && ARREADY) check_a(1'b0, ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
      if (WVALID && WREADY) begin
        chk("w_expected", exp_w_data.size() > 0, 1);
        if (exp_w_data.size() > 0) begin
          chk("wdata", WDATA, exp_w_data.pop_front());
          chk("wlast", WLAST, exp_w_last.pop_front());
          chk("wstrb", WSTRB, 4'hF);
        end
        w_beats++;
        if (WLAST) wlast_cnt++;
      end
      if (rd_valid && rd_ready) begin
        chk("rd_expected", exp_rd_data.size() > 0, 1);
        if (exp_rd_data.size() > 0) begin
          chk("rd_data", rd_data, exp_rd_data.pop_front());
          chk("rd_last", rd_last, exp_rd_last.pop_front());
        end
        if (rd_beats < 16) rd_hist[rd_beats] = rd_data;
        rd_beats++;
        if (rd_last) rd_last_cnt++;
      end
      if (rsp_valid) begin
        chk("rsp_expected", exp_rsp_resp.size() > 0, 1);
        if (exp_rsp_resp.size() > 0) begin
          chk("rsp_resp", rsp_resp, exp_rsp_resp.pop_front());
          chk("rsp_err", rsp_err, exp_rsp_err.pop_front());
        end
        rsp_count++;
        rsp_cyc   = cyc;
        last_resp = rsp_resp;
        last_err  = rsp_err;
      end
    end
  end

  // ---------------- zero-wait SRAM slave with fault knobs ----------------
  logic [31:0] slv_mem [1024];
  logic [7:0]  bid_xor = 8'h00;
  logic [1:0]  s_bresp = OKAY;
  int          rresp_beat = -1;
  logic [1:0]  rresp_val = OKAY;
  int          rlast_fault = -1;
  logic [31:0] s_waddr, s_raddr;
  logic [7:0]  s_wid, s_rid;
  int          s_rlen, s_rbeat;

  task automatic drive_r();
    logic [9:0] ix;
    ix    = s_raddr[11:2] + 10'(s_rbeat);
    RDATA = slv_mem[ix];
    RID   = s_rid;
    RRESP = (s_rbeat == rresp_beat) ? rresp_val : OKAY;
    RLAST = (s_rbeat == s_rlen) || (s_rbeat == rlast_fault);
  endtask

  always begin : slave
    logic aw_h, w_h, wl, b_h, ar_h, r_h;
    logic [31:0] aw_a, w_d, ar_a;
    logic [7:0]  aw_i, ar_i;
    logic [3:0]  w_s, ar_l;
    @(negedge ACLK);
    aw_h = AWVALID && AWREADY; aw_a = AWADDR; aw_i = AWID;
    w_h  = WVALID && WREADY;   w_d = WDATA; w_s = WSTRB; wl = WLAST;
    b_h  = BVALID && BREADY;
    ar_h = ARVALID && ARREADY; ar_a = ARADDR; ar_i = ARID; ar_l = ARLEN;
    r_h  = RVALID && RREADY;
    @(posedge ACLK);
    #1;
    if (!ARESETn) begin
      BVALID = 1'b0;
      RVALID = 1'b0;
    end else begin
      if (b_h) BVALID = 1'b0;
      if (aw_h) begin s_waddr = aw_a; s_wid = aw_i; end
      if (w_h) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) slv_mem[s_waddr[11:2]][8*b +: 8] = w_d[8*b +: 8];
        s_waddr = s_waddr + 32'd4;
        if (wl) begin BVALID = 1'b1; BID = s_wid ^ bid_xor; BRESP = s_bresp; end
      end
      if (r_h) begin
        s_rbeat++;
        if (s_rbeat > s_rlen) RVALID = 1'b0;
        else drive_r();
      end
      if (ar_h) begin
        s_raddr = ar_a; s_rid = ar_i; s_rlen = int'(ar_l); s_rbeat = 0;
        RVALID = 1'b1;
        drive_r();
      end
    end
  end

  // ---------------- client-side driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, output int c_acc);
    logic hs;
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
    hs = 1'b0; n = 0; c_acc = 0;
    while (!hs && n < 50) begin
      @(negedge ACLK); hs = cmd_ready; c_acc = cyc;
      @(posedge ACLK); #1; n++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", hs, 1);
  endtask

  task automatic send_wd(input logic [31:0] d);
    logic hs;
    int n;
    wd_valid = 1'b1; wd_data = d; wd_strb = 4'hF; hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge ACLK); hs = wd_ready;
      @(posedge ACLK); #1; n++;
    end
    wd_valid = 1'b0;
    chk("wd_accepted", hs, 1);
  endtask

  task automatic wait_rsp(input int r0, input int c_acc, output int lat);
    int n;
    n = 0;
    while (rsp_count == r0 && n < 60) begin @(posedge ACLK); #1; n++; end
    chk("rsp_seen", rsp_count - r0, 1);
    lat = rsp_cyc - c_acc;
  endtask

  int last_lat;

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [31:0] base, input logic [1:0] er, input logic ee);
    logic rej, saw_ready;
    int c_acc, r0;
    logic [9:0] ix;
    rej = CHK4K && ((32'(addr[11:0]) + (32'(len) + 32'd1) * 32'd4) > 32'd4096);
    if (rej) begin
      exp_rsp_resp.push_back(SLVERR); exp_rsp_err.push_back(1'b1);
    end else begin
      exp_a_wr.push_back(1'b1); exp_a_id.push_back(id); exp_a_addr.push_back(addr); exp_a_len.push_back(len);
      for (int i = 0; i <= int'(len); i++) begin
        exp_w_data.push_back(base + 32'(i));
        exp_w_last.push_back(i == int'(len));
        ix = addr[11:2] + 10'(i);
        model_mem[ix] = base + 32'(i);
      end
      exp_rsp_resp.push_back(er); exp_rsp_err.push_back(ee);
    end
    r0 = rsp_count;
    send_cmd(1'b1, id, addr, len, c_acc);
    if (rej) begin
      saw_ready = 1'b0;
      repeat (3) begin @(negedge ACLK); saw_ready |= wd_ready; @(posedge ACLK); #1; end
      chk("rej_wd_ready", saw_ready, 0);
      wait_rsp(r0, c_acc, last_lat);
      chk("rej_latency", last_lat, 1);
    end else begin
      for (int i = 0; i <= int'(len); i++) send_wd(base + 32'(i));
      wait_rsp(r0, c_acc, last_lat);
    end
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input int rb, input logic [1:0] rv, input int rlf);
    logic [1:0] er;
    logic ee, hs;
    int c_acc, r0, beats, n, lat;
    logic [9:0] ix;
    rresp_beat = rb; rresp_val = rv; rlast_fault = rlf;
    er = OKAY; ee = 1'b0;
    exp_a_wr.push_back(1'b0); exp_a_id.push_back(id); exp_a_addr.push_back(addr); exp_a_len.push_back(len);
    for (int i = 0; i <= int'(len); i++) begin
      ix = addr[11:2] + 10'(i);
      exp_rd_data.push_back(model_mem[ix]);
      exp_rd_last.push_back(i == int'(len));
      if (i == rb && rv > er) er = rv;
      if (i == rlf && i != int'(len)) ee = 1'b1;
    end
    exp_rsp_resp.push_back(er); exp_rsp_err.push_back(ee);
    r0 = rsp_count;
    send_cmd(1'b0, id, addr, len, c_acc);
    beats = 0; n = 0;
    while (beats <= int'(len) && n < 100) begin
      rd_ready = (n % 2 == 0);
      @(negedge ACLK); hs = rd_valid && rd_ready;
      @(posedge ACLK); #1;
      if (hs) beats++;
      n++;
    end
    rd_ready = 1'b0;
    chk("rd_beats_done", beats, int'(len) + 1);
    wait_rsp(r0, c_acc, lat);
    rresp_beat = -1; rresp_val = OKAY; rlast_fault = -1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r0, c_acc;
    for (int i = 0; i < 1024; i++) begin model_mem[i] = 32'h0; slv_mem[i] = 32'h0; end
    cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
    AWREADY = 1; WREADY = 1; ARREADY = 1;
    BVALID = 0; BID = 0; BRESP = 0;
    RVALID = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0;

    // reset state
    #3;
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_awid", AWID, 0);
    chk("rst_awlen", AWLEN, 0);
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETn = 1'b1;
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // write 0x100 len 3, data A0..A3
    w_beats = 0; wlast_cnt = 0;
    do_write(8'h01, 32'h100, 4'd3, 32'hA0, OKAY, 1'b0);
    chk("t1_w_beats", w_beats, 4);
    chk("t1_wlast_count", wlast_cnt, 1);
    chk("t1_resp_lit", last_resp, 2'b00);
    chk("t1_err_lit", last_err, 0);

    // read back with rd_ready toggling
    rd_beats = 0; rd_last_cnt = 0;
    do_read(8'h02, 32'h100, 4'd3, -1, OKAY, -1);
    chk("t2_beat0_lit", rd_hist[0], 32'hA0);
    chk("t2_beat1_lit", rd_hist[1], 32'hA1);
    chk("t2_beat3_lit", rd_hist[3], 32'hA3);
    chk("t2_rd_last_count", rd_last_cnt, 1);

    // minimum write latency
    do_write(8'h03, 32'h40, 4'd0, 32'h12345678, OKAY, 1'b0);
    chk("t3_latency_lit", last_lat, 4);

    // BID mismatch: slave answers 0x05 to id 0x04
    bid_xor = 8'h01;
    do_write(8'h04, 32'h80, 4'd1, 32'h55, OKAY, 1'b1);
    bid_xor = 8'h00;
    chk("t4_err_lit", last_err, 1);

    // RLAST on beat 2 of a 4-beat read
    rd_beats = 0;
    do_read(8'h05, 32'h100, 4'd3, -1, OKAY, 1);
    chk("t5_err_lit", last_err, 1);
    chk("t5_beats_lit", rd_beats, 4);

    // worst response accumulation
    do_read(8'h06, 32'h100, 4'd3, 2, SLVERR, -1);
    chk("t6_rresp_lit", last_resp, 2'b10);
    s_bresp = DECERR;
    do_write(8'h07, 32'hC0, 4'd0, 32'h77, DECERR, 1'b0);
    s_bresp = OKAY;
    chk("t6_bresp_lit", last_resp, 2'b11);

    // reset during the second write beat
    exp_a_wr.push_back(1'b1); exp_a_id.push_back(8'h09); exp_a_addr.push_back(32'h200); exp_a_len.push_back(4'd3);
    exp_w_data.push_back(32'hC0); exp_w_last.push_back(1'b0);
    r0 = rsp_count;
    send_cmd(1'b1, 8'h09, 32'h200, 4'd3, c_acc);
    send_wd(32'hC0);
    wd_valid = 1'b1; wd_data = 32'hC1; wd_strb = 4'hF;
    #1;
    chk("t7_wvalid_before_reset", WVALID, 1);
    #1;
    ARESETn = 1'b0;
    #1;
    chk("t7_wvalid", WVALID, 0);
    chk("t7_wd_ready", wd_ready, 0);
    chk("t7_awvalid", AWVALID, 0);
    chk("t7_bready", BREADY, 0);
    chk("t7_arvalid", ARVALID, 0);
    chk("t7_rready", RREADY, 0);
    chk("t7_rsp_valid", rsp_valid, 0);
    wd_valid = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    chk("t7_cmd_ready", cmd_ready, 1);
    repeat (8) @(posedge ACLK);
    #1;
    chk("t7_no_rsp", rsp_count - r0, 0);
    chk("t7_awvalid_idle", AWVALID, 0);

    // 4 KB boundary command
    do_write(8'h0A, 32'hFFC, 4'd1, 32'hB0, OKAY, 1'b0);
    chk("t8_resp_lit", last_resp, CHK4K ? 2'b10 : 2'b00);
    chk("t8_err_lit", last_err, CHK4K ? 1'b1 : 1'b0);

    repeat (3) @(posedge ACLK);
    #1;
    chk("end_queues_empty", exp_rsp_resp.size() + exp_a_wr.size() + exp_w_data.size() + exp_rd_data.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Single-outstanding AXI4 master that sits directly upstream of the AXI4 SRAM slave and drives all five of its channels. It accepts simple command, write-data and read-data streams from a local client and converts each command into one INCR burst. It checks the slave's response ID and RLAST placement, and reports one completion per command.

## Interface
Parameters:
- ID_W, 8: AXI ID width (matches `AXI_IDS_BITS)
- ADDR_W, 32: address width
- DATA_W, 32: data width; STRB_W = DATA_W/8
- LEN_W, 4: burst length field width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_id  in  ID_W  transaction ID
- cmd_addr  in  ADDR_W  start byte address, word aligned
- cmd_len  in  LEN_W  beats minus one
- wd_valid / wd_ready  in / out  1  write-data handshake
- wd_data / wd_strb  in  DATA_W / STRB_W  write beat payload
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_W  read beat
- rd_last  out  1  final beat of the read burst
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_resp  out  2  worst BRESP/RRESP seen
- rsp_err  out  1  protocol error (ID mismatch or RLAST misplacement)
- AW*, W*, B*, AR*, R*  AXI4 master side; same names and widths as the slave's ports

## Operation
- FSM states: IDLE, AW, W, B, AR, R.
  - IDLE: cmd_ready=1. On a command handshake, register id/addr/len, clear the beat counter, and go to AW (write) or AR (read).
  - AW: AWVALID=1; AWID/AWADDR/AWLEN come from the registers. AWSIZE=log2(STRB_W), AWBURST=2'b01. On AWREADY, go to W.
  - W: WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB pass through combinationally. WLAST=1 when beat count == len. Each handshake increments the count. On the last beat, go to B.
  - B: BREADY=1. On BVALID, pulse rsp_valid with rsp_resp=BRESP and rsp_err=(BID!=id), then go to IDLE.
  - AR: same as AW using AR*. On ARREADY, go to R.
  - R: rd_valid=RVALID, RREADY=rd_ready, rd_data=RDATA, rd_last=(count==len).
    - rsp_resp accumulates the max RRESP over all beats.
    - rsp_err is set if RID!=id on any beat, or if RLAST != (count==len) on any beat.
    - On the beat where count==len, pulse rsp_valid and go to IDLE. The burst always ends on the expected count.
- Beat counter is LEN_W bits, so it never wraps within a legal burst.
- Valid signals never deassert before ready; payload is stable while valid is held.

## Timing
- Reset (asynchronous assert): FSM=IDLE. The following are 0: AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_err, rsp_resp, and all registered address/ID/len. cmd_ready=1 on the first cycle after reset release.
- Reset asserted mid-burst aborts immediately: no completion, no further AXI beats.
- Command accepted at edge N gives AWVALID/ARVALID=1 in cycle N+1.
- AWREADY at edge M: W beats may handshake from cycle M+1.
- The last W handshake at edge K gives BREADY=1 from cycle K+1.
- The rsp_valid pulse is registered. It appears the cycle after the B handshake or the final R handshake. cmd_ready returns the same cycle.
- Minimum write of len=0: 4 cycles from command to rsp_valid with a zero-wait slave.
- Beat pass-through adds no latency.

## Configuration
- AXI_MST_4K_CHECK_EN defined: in IDLE, a command with (addr[11:0] + (len+1)*STRB_W) > 4096 is still accepted. No AXI traffic is issued, and the FSM returns to IDLE.
  - The cycle after acceptance: rsp_valid=1, rsp_resp=2'b10, rsp_err=1.
  - For a rejected write, wd_ready stays 0, so the client must not present write data.
- Undefined: no check; every command issues a burst.

## Structure
- Shared package axi_mst_pkg holds:
  - state enum typedef
  - response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - BURST_INCR=2'b01
- One sub-module is natural: axi_mst_beat_cnt (clear, increment, last-beat compare against len). It is shared by the W and R states.

## Test plan
- Write: addr 0x100, len 3, data 0xA0..0xA3, zero-wait slave -> AWLEN=3, WLAST only on the 4th beat, rsp_valid with rsp_resp=0, rsp_err=0.
- Read back: addr 0x100, len 3, rd_ready toggling every other cycle -> rd_data 0xA0..0xA3 in order, rd_last on the 4th beat, no beat lost.
- Slave returns BID=0x05 for cmd_id=0x04 -> rsp_err=1.
- Slave asserts RLAST on beat 2 of a len=3 read -> rsp_err=1; completion still after beat 4.
- ARESETn low during W beat 2 -> all valids 0 asynchronously; after release, cmd_ready=1 and no rsp_valid.
- With AXI_MST_4K_CHECK_EN: addr 0xFFC, len 1 -> no AWVALID, rsp_resp=2'b10, rsp_err=1. Without the macro: burst issued.
